alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Registered ALU DUT that responds to the ALU verification interface.
- Consumes opa, opb, cmd, inp_valid, ce, cin and mode from the driver side.
- Produces res, cout, oflow, g, l, e and err, which the monitor samples at posedge clk.
- Supports split operand delivery with a 16-cycle wait window, and two-cycle multiply commands.

Parameters:
- WIDTH, 8, operand width (the `width define).
- CMD_WIDTH, 4, command field width (the `cmd_width define).
- TIMEOUT, 16, cycles allowed for the missing operand to arrive.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- opa  input  WIDTH  operand A.
- opb  input  WIDTH  operand B.
- cmd  input  CMD_WIDTH  operation select.
- inp_valid  input  2  operand qualifiers: bit0 = opa valid, bit1 = opb valid.
- ce  input  1  clock enable; 0 freezes all state and outputs.
- cin  input  1  carry in.
- mode  input  1  1 = arithmetic, 0 = logical.
- res  output  WIDTH+2  result.
- cout  output  1  carry out.
- oflow  output  1  borrow / overflow.
- g  output  1  opa > opb.
- l  output  1  opa < opb.
- e  output  1  opa == opb.
- err  output  1  error.

Behaviour:
- Reset:
  - rst low → all outputs 0, state IDLE, wait counter 0, held operands 0.
  - Takes effect immediately (asynchronous), including mid-WAIT and mid-MUL.
- ce=0: no state change and outputs hold their values. This includes the wait counter, which does not advance.
- Arithmetic commands (mode=1):
  - 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B
  - 8 CMP
  - 9 MUL_INC = (opa+1)*(opb+1)
  - 10 MUL_SHL = (opa<<1)*opb
- Logical commands (mode=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT_A, 7 NOT_B
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B
  - 12 ROL_A_B, 13 ROR_A_B
  - Logical results are zero-extended to WIDTH+2.
- Arithmetic width: computed unsigned, wrapping modulo 2^(WIDTH+2).
- Flags:
  - cout = bit WIDTH of the sum for ADD/ADD_CIN/INC.
  - oflow = 1 when opa < opb+cin for SUB/SUB_CIN, and on DEC of 0.
  - CMP: exactly one of g/l/e is 1, and res=0.
  - Flags not defined for the current command are 0. Every new result clears the previous flags.
- Operand requirements:
  - Unary A ops need inp_valid[0]; unary B ops need inp_valid[1].
  - If the needed operand is absent: err=1, res=0.
  - inp_valid=00 → no operation; outputs hold.
- Invalid cmd (arithmetic >10, logical >13) → err=1, res=0.
- Rotates:
  - Amount is opb[log2(WIDTH)-1:0].
  - If any higher bit of opb is set: err=1, and the rotated res is still driven.
- Latency:
  - Non-multiply ops: result on the first posedge after the beat that completes the operands.
  - Multiply: result on the second posedge after that beat.
- FSM states: IDLE, WAIT, MUL.
  - IDLE + binary op with only one operand valid:
    - Capture that operand, plus cmd, mode and cin.
    - Go to WAIT with counter=1; outputs hold.
  - WAIT, on a beat carrying the missing operand (inp_valid 01, 10 or 11):
    - Take the missing operand.
    - Finish the captured cmd; any new cmd/mode is ignored.
    - Go to IDLE, or to MUL for multiply.
  - WAIT, on a beat carrying only the already-held operand: overwrite the held value; counter keeps counting.
  - WAIT, counter reaching TIMEOUT without completion: err=1 and res=0 on that edge, then go to IDLE.
  - MUL: one extra cycle. Inputs are ignored. Result is registered, then go to IDLE.
  - IDLE + complete operands + multiply: go to MUL.

Test Plan:
- Reset low, then high; ADD, mode=1, opa=0xF0, opb=0x20, inp_valid=11, ce=1 → next edge: res=0x110, cout=1, err=0.
- SUB, opa=0x10, opb=0x20 → res=0x3F0, oflow=1. Then CMP, opa=5, opb=5 → e=1, g=0, l=0, res=0.
- MUL_INC, opa=3 with inp_valid=01; 4 cycles of inp_valid=00; then opb=5 with inp_valid=10 → res=0x018 two edges after the opb beat; no output change before that.
- ADD, opa=7 with inp_valid=01, then 00 for the rest of the window → err=1, res=0 on the 16th edge after the first beat; the next 11 beat is handled from IDLE.
- ROL_A_B, mode=0, opa=0x81, opb=0x01 → res=0x003, err=0. Same with opb=0x09 → res=0x003, err=1. Then cmd=15, mode=0 → err=1, res=0.
- Drop rst low mid-WAIT and mid-MUL → all outputs 0 immediately. ce=0 during WAIT for 20 cycles → no timeout, outputs frozen.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: registered ALU with split operand delivery and two-cycle multiplies.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous active-low reset
//   opa, opb   operands (WIDTH bits)
//   cmd        operation select (CMD_WIDTH bits)
//   inp_valid  operand qualifiers: bit0 = opa valid, bit1 = opb valid
//   ce         clock enable; 0 freezes all state and outputs
//   cin        carry in
//   mode       1 = arithmetic, 0 = logical
//   res        result (WIDTH+2 bits)
//   cout       carry out (ADD, ADD_CIN, INC_A, INC_B)
//   oflow      borrow (SUB, SUB_CIN) or decrement of zero
//   g, l, e    compare flags (CMP only)
//   err        missing operand, invalid command, timeout or bad rotate amount
//
// A binary op that arrives with only one operand parks in WAIT until the other
// operand shows up or TIMEOUT cycles pass. Multiplies spend one extra cycle in MUL.
module alu_core #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic [1:0]           inp_valid,
    input  logic                 ce,
    input  logic                 cin,
    input  logic                 mode,
    output logic [WIDTH+1:0]     res,
    output logic                 cout,
    output logic                 oflow,
    output logic                 g,
    output logic                 l,
    output logic                 e,
    output logic                 err
);

    localparam int RW    = WIDTH + 2;
    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL} state_t;
    typedef enum logic [1:0] {OP_BIN, OP_UA, OP_UB, OP_BAD} op_class_t;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          cout;
        logic          oflow;
        logic          g;
        logic          l;
        logic          e;
        logic          err;
    } alu_out_t;

    localparam alu_out_t ERR_OUT = '{res: '0, cout: 1'b0, oflow: 1'b0,
                                     g: 1'b0, l: 1'b0, e: 1'b0, err: 1'b1};

    function automatic op_class_t classify(input logic [CMD_WIDTH-1:0] c, input logic m);
        op_class_t k;
        k = OP_BAD;
        if (m) begin
            case (int'(c))
                0, 1, 2, 3, 8, 9, 10: k = OP_BIN;
                4, 5:                 k = OP_UA;
                6, 7:                 k = OP_UB;
                default:              k = OP_BAD;
            endcase
        end else begin
            case (int'(c))
                0, 1, 2, 3, 4, 5, 12, 13: k = OP_BIN;
                6, 8, 9:                  k = OP_UA;
                7, 10, 11:                k = OP_UB;
                default:                  k = OP_BAD;
            endcase
        end
        return k;
    endfunction

    function automatic logic is_mul(input logic [CMD_WIDTH-1:0] c, input logic m);
        return m && (int'(c) == 9 || int'(c) == 10);
    endfunction

    function automatic alu_out_t compute(input logic [CMD_WIDTH-1:0] c, input logic m,
                                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic ci);
        alu_out_t           o;
        logic [RW-1:0]      ea, eb, ec;
        logic [WIDTH-1:0]   lr;
        logic [2*WIDTH-1:0] dbl;
        // NOTE: every local gets a value before any branch so no path leaves it stale.
        o   = '0;
        lr  = '0;
        ea  = RW'(a);
        eb  = RW'(b);
        ec  = RW'(ci);
        dbl = {a, a};
        if (m) begin
            case (int'(c))
                0:  begin o.res = ea + eb;           o.cout  = o.res[WIDTH]; end
                1:  begin o.res = ea - eb;           o.oflow = (ea < eb); end
                2:  begin o.res = ea + eb + ec;      o.cout  = o.res[WIDTH]; end
                3:  begin o.res = ea - eb - ec;      o.oflow = (ea < eb + ec); end
                4:  begin o.res = ea + RW'(1);       o.cout  = o.res[WIDTH]; end
                5:  begin o.res = ea - RW'(1);       o.oflow = (a == '0); end
                6:  begin o.res = eb + RW'(1);       o.cout  = o.res[WIDTH]; end
                7:  begin o.res = eb - RW'(1);       o.oflow = (b == '0); end
                8:  begin o.g = (a > b); o.l = (a < b); o.e = (a == b); end
                9:  o.res = (ea + RW'(1)) * (eb + RW'(1));
                10: o.res = (ea << 1) * eb;
                default: o.err = 1'b1;
            endcase
        end else begin
            case (int'(c))
                0:  lr = a & b;
                1:  lr = ~(a & b);
                2:  lr = a | b;
                3:  lr = ~(a | b);
                4:  lr = a ^ b;
                5:  lr = ~(a ^ b);
                6:  lr = ~a;
                7:  lr = ~b;
                8:  lr = a >> 1;
                9:  lr = a << 1;
                10: lr = b >> 1;
                11: lr = b << 1;
                // Rotating the doubled word turns a rotate into a plain shift.
                12: begin
                    dbl   = dbl << b[SHW-1:0];
                    lr    = dbl[2*WIDTH-1:WIDTH];
                    o.err = |b[WIDTH-1:SHW];
                end
                13: begin
                    dbl   = dbl >> b[SHW-1:0];
                    lr    = dbl[WIDTH-1:0];
                    o.err = |b[WIDTH-1:SHW];
                end
                default: o.err = 1'b1;
            endcase
            o.res = RW'(lr);
        end
        return o;
    endfunction

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 mode_q, cin_q;
    logic                 have_a;    // 1: WAIT holds opa and needs opb; 0: the reverse
    alu_out_t             out_q;

    op_class_t            cls;
    logic [WIDTH-1:0]     fa, fb;
    logic                 got_missing;

    always_comb begin
        cls         = classify(cmd, mode);
        fa          = have_a ? a_q : opa;
        fb          = have_a ? opb : b_q;
        got_missing = have_a ? inp_valid[1] : inp_valid[0];
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cmd_q  <= '0;
            mode_q <= 1'b0;
            cin_q  <= 1'b0;
            have_a <= 1'b0;
            out_q  <= '0;
        end else if (ce) begin
            case (state)
                S_IDLE: begin
                    if (inp_valid != 2'b00) begin
                        unique case (cls)
                            OP_BAD: out_q <= ERR_OUT;
                            OP_UA:  out_q <= inp_valid[0] ? compute(cmd, mode, opa, opb, cin) : ERR_OUT;
                            OP_UB:  out_q <= inp_valid[1] ? compute(cmd, mode, opa, opb, cin) : ERR_OUT;
                            OP_BIN: begin
                                cmd_q  <= cmd;
                                mode_q <= mode;
                                cin_q  <= cin;
                                if (inp_valid == 2'b11) begin
                                    if (is_mul(cmd, mode)) begin
                                        a_q   <= opa;
                                        b_q   <= opb;
                                        state <= S_MUL;
                                    end else begin
                                        out_q <= compute(cmd, mode, opa, opb, cin);
                                    end
                                end else begin
                                    if (inp_valid[0]) a_q <= opa;
                                    else              b_q <= opb;
                                    have_a <= inp_valid[0];
                                    cnt    <= CNT_W'(1);
                                    state  <= S_WAIT;
                                end
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (got_missing) begin
                        cnt <= '0;
                        if (is_mul(cmd_q, mode_q)) begin
                            a_q   <= fa;
                            b_q   <= fb;
                            state <= S_MUL;
                        end else begin
                            out_q <= compute(cmd_q, mode_q, fa, fb, cin_q);
                            state <= S_IDLE;
                        end
                    end else begin
                        if (have_a && inp_valid[0])  a_q <= opa;
                        if (!have_a && inp_valid[1]) b_q <= opb;
                        // cnt counts the edge just taken, so TIMEOUT-1 here is the TIMEOUT-th edge.
                        if (cnt == CNT_W'(TIMEOUT - 1)) begin
                            out_q <= ERR_OUT;
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_MUL: begin
                    out_q <= compute(cmd_q, mode_q, a_q, b_q, cin_q);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign res   = out_q.res;
    assign cout  = out_q.cout;
    assign oflow = out_q.oflow;
    assign g     = out_q.g;
    assign l     = out_q.l;
    assign e     = out_q.e;
    assign err   = out_q.err;

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core (WIDTH=8).
// Inputs change 1 time unit after a posedge; outputs are sampled there too.
module tb_alu_core;

    logic       clk;
    logic       rst;
    logic [7:0] opa, opb;
    logic [3:0] cmd;
    logic [1:0] inp_valid;
    logic       ce, cin, mode;
    logic [9:0] res;
    logic       cout, oflow, g, l, e, err;
    logic [5:0] flags;

    int n_checks = 0;
    int n_errors = 0;

    // Flag vector order: {cout, oflow, g, l, e, err}
    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_COUT  = 6'b100000;
    localparam logic [5:0] F_OFLOW = 6'b010000;
    localparam logic [5:0] F_G     = 6'b001000;
    localparam logic [5:0] F_L     = 6'b000100;
    localparam logic [5:0] F_E     = 6'b000010;
    localparam logic [5:0] F_ERR   = 6'b000001;

    assign flags = {cout, oflow, g, l, e, err};

    alu_core #(.WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .opa       (opa),
        .opb       (opb),
        .cmd       (cmd),
        .inp_valid (inp_valid),
        .ce        (ce),
        .cin       (cin),
        .mode      (mode),
        .res       (res),
        .cout      (cout),
        .oflow     (oflow),
        .g         (g),
        .l         (l),
        .e         (e),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [9:0] r, input logic [5:0] f);
        check({tag, " res"}, 32'(res), 32'(r));
        check({tag, " flags"}, 32'(flags), 32'(f));
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] iv, input logic ci);
        mode      = m;
        cmd       = c;
        opa       = a;
        opb       = b;
        inp_valid = iv;
        cin       = ci;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ce  = 1'b1;
        drive(1'b0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0);
        #3;
        expect_out("reset", 10'h000, F_NONE);
        tick();
        rst = 1'b1;

        // Arithmetic, both operands on one beat
        drive(1'b1, 4'd0, 8'hF0, 8'h20, 2'b11, 1'b0); tick();
        expect_out("add", 10'h110, F_COUT);
        drive(1'b1, 4'd1, 8'h10, 8'h20, 2'b11, 1'b0); tick();
        expect_out("sub", 10'h3F0, F_OFLOW);
        drive(1'b1, 4'd8, 8'h05, 8'h05, 2'b11, 1'b0); tick();
        expect_out("cmp_eq", 10'h000, F_E);
        drive(1'b1, 4'd8, 8'h03, 8'h09, 2'b11, 1'b0); tick();
        expect_out("cmp_lt", 10'h000, F_L);
        drive(1'b1, 4'd8, 8'h09, 8'h03, 2'b11, 1'b0); tick();
        expect_out("cmp_gt", 10'h000, F_G);
        drive(1'b1, 4'd2, 8'hF0, 8'h0F, 2'b11, 1'b1); tick();
        expect_out("add_cin", 10'h100, F_COUT);
        drive(1'b1, 4'd3, 8'h05, 8'h05, 2'b11, 1'b1); tick();
        expect_out("sub_cin", 10'h3FF, F_OFLOW);

        // Unary ops and missing operand
        drive(1'b1, 4'd5, 8'h00, 8'hAA, 2'b01, 1'b0); tick();
        expect_out("dec_a_zero", 10'h3FF, F_OFLOW);
        drive(1'b1, 4'd6, 8'h55, 8'hFF, 2'b10, 1'b0); tick();
        expect_out("inc_b", 10'h100, F_COUT);
        drive(1'b1, 4'd4, 8'h01, 8'h01, 2'b10, 1'b0); tick();
        expect_out("inc_a_missing", 10'h000, F_ERR);

        // Logical
        drive(1'b0, 4'd1, 8'hF0, 8'hCC, 2'b11, 1'b0); tick();
        expect_out("nand", 10'h03F, F_NONE);
        drive(1'b0, 4'd6, 8'h0F, 8'h00, 2'b01, 1'b0); tick();
        expect_out("not_a", 10'h0F0, F_NONE);
        drive(1'b0, 4'd9, 8'h81, 8'h00, 2'b01, 1'b0); tick();
        expect_out("shl1_a", 10'h002, F_NONE);

        // Split MUL_INC: opa now, opb after four idle beats; new cmd on opb beat ignored
        drive(1'b1, 4'd9, 8'h03, 8'h00, 2'b01, 1'b0); tick();
        expect_out("mul_split_wait", 10'h002, F_NONE);
        drive(1'b1, 4'd0, 8'h77, 8'h77, 2'b00, 1'b0);
        repeat (4) tick();
        expect_out("mul_split_idle", 10'h002, F_NONE);
        drive(1'b0, 4'd0, 8'h77, 8'h05, 2'b10, 1'b0); tick();
        expect_out("mul_split_stage", 10'h002, F_NONE);
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0); tick();
        expect_out("mul_inc", 10'h018, F_NONE);

        // MUL_SHL with both operands
        drive(1'b1, 4'd10, 8'h81, 8'h03, 2'b11, 1'b0); tick();
        expect_out("mul_shl_stage", 10'h018, F_NONE);
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0); tick();
        expect_out("mul_shl", 10'h306, F_NONE);

        // Timeout: first beat is edge 1, error lands on edge 16
        drive(1'b1, 4'd0, 8'h07, 8'h00, 2'b01, 1'b0); tick();
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0);
        repeat (14) tick();
        expect_out("timeout_edge15", 10'h306, F_NONE);
        tick();
        expect_out("timeout_edge16", 10'h000, F_ERR);
        drive(1'b1, 4'd0, 8'h01, 8'h02, 2'b11, 1'b0); tick();
        expect_out("after_timeout", 10'h003, F_NONE);

        // Rotates and invalid commands
        drive(1'b0, 4'd12, 8'h81, 8'h01, 2'b11, 1'b0); tick();
        expect_out("rol", 10'h003, F_NONE);
        drive(1'b0, 4'd12, 8'h81, 8'h09, 2'b11, 1'b0); tick();
        expect_out("rol_bad_amt", 10'h003, F_ERR);
        drive(1'b0, 4'd13, 8'h81, 8'h01, 2'b11, 1'b0); tick();
        expect_out("ror", 10'h0C0, F_NONE);
        drive(1'b0, 4'd15, 8'h81, 8'h01, 2'b11, 1'b0); tick();
        expect_out("bad_cmd_logic", 10'h000, F_ERR);
        drive(1'b1, 4'd11, 8'h81, 8'h01, 2'b11, 1'b0); tick();
        expect_out("bad_cmd_arith", 10'h000, F_ERR);

        // Asynchronous reset in the middle of WAIT
        drive(1'b1, 4'd0, 8'h01, 8'h02, 2'b11, 1'b0); tick();
        expect_out("pre_rst_wait", 10'h003, F_NONE);
        drive(1'b1, 4'd0, 8'h09, 8'h00, 2'b01, 1'b0); tick();
        #2 rst = 1'b0;
        #1;
        expect_out("rst_mid_wait", 10'h000, F_NONE);
        tick();
        rst = 1'b1;
        drive(1'b1, 4'd0, 8'h04, 8'h04, 2'b11, 1'b0); tick();
        expect_out("post_rst_wait", 10'h008, F_NONE);

        // Asynchronous reset in the middle of MUL
        drive(1'b1, 4'd9, 8'h01, 8'h01, 2'b11, 1'b0); tick();
        expect_out("mul_before_rst", 10'h008, F_NONE);
        #2 rst = 1'b0;
        #1;
        expect_out("rst_mid_mul", 10'h000, F_NONE);
        tick();
        rst = 1'b1;
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0); tick();
        expect_out("post_rst_mul", 10'h000, F_NONE);

        // ce=0 in WAIT: nothing moves, including the timeout counter
        drive(1'b1, 4'd0, 8'h10, 8'h01, 2'b11, 1'b0); tick();
        expect_out("pre_ce", 10'h011, F_NONE);
        drive(1'b1, 4'd0, 8'h20, 8'h00, 2'b01, 1'b0); tick();
        ce = 1'b0;
        drive(1'b1, 4'd0, 8'h00, 8'h03, 2'b10, 1'b0);
        repeat (20) tick();
        expect_out("ce0_frozen", 10'h011, F_NONE);
        ce = 1'b1;
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0);
        repeat (14) tick();
        expect_out("ce0_no_timeout", 10'h011, F_NONE);
        drive(1'b1, 4'd0, 8'h00, 8'h03, 2'b10, 1'b0); tick();
        expect_out("ce_resume", 10'h023, F_NONE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
